// File: rtl/vec_switch_if.sv
// Core-side bundle of the vector switch: per-core send, receive and pending lanes.
// The master modport is the core cluster; the slave modport is the switch itself.
interface vec_switch_if #(
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_WIDTH          = 16,
    parameter int DATA_WIDTH            = 32,
    parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
);
    localparam int N   = SWITCH_CORE_SIZE;
    localparam int AW  = SWITCH_CORE_ADDR_SIZE;
    localparam int PKT = SWITCH_WIDTH * DATA_WIDTH;

    logic [N-1:0]     switch_send_ready;
    logic [N*AW-1:0]  switch_send_core_idx;
    logic [N*PKT-1:0] switch_send_data;
    logic [N-1:0]     switch_send_ok;
    logic [N-1:0]     switch_recv_request;
    logic [N*AW-1:0]  switch_recv_core_idx;
    logic [N-1:0]     switch_recv_ready;
    logic [N*PKT-1:0] switch_recv_data;
    logic [N-1:0]     switch_pending;

    modport master (
        output switch_send_ready, switch_send_core_idx, switch_send_data,
        output switch_recv_request, switch_recv_core_idx,
        input  switch_send_ok, switch_recv_ready, switch_recv_data, switch_pending
    );

    modport slave (
        input  switch_send_ready, switch_send_core_idx, switch_send_data,
        input  switch_recv_request, switch_recv_core_idx,
        output switch_send_ok, switch_recv_ready, switch_recv_data, switch_pending
    );
endinterface

// File: rtl/vec_switch.sv
// Crossbar of per-(source,destination) packet FIFOs between vector cores.
// Each FIFO has exactly one writer (its source row) and one reader (its destination column).
module vec_switch #(
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_WIDTH          = 16,
    parameter int DATA_WIDTH            = 32,
    parameter int FIFO_DEPTH            = 2,
    parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    vec_switch_if.slave   sw
);
    localparam int N   = SWITCH_CORE_SIZE;
    localparam int AW  = SWITCH_CORE_ADDR_SIZE;
    localparam int PKT = SWITCH_WIDTH * DATA_WIDTH;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [PKT-1:0] r_mem    [N][N][FIFO_DEPTH];
    logic [PW-1:0]  r_rd_ptr [N][N];
    logic [PW-1:0]  r_wr_ptr [N][N];
    logic [CW-1:0]  r_count  [N][N];

    logic [N-1:0][N-1:0] w_push;
    logic [N-1:0][N-1:0] w_pop;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Handshake decode: pops first, since a pop frees a slot for a push to a full FIFO.
    always_comb begin
        w_pop                = '0;
        w_push               = '0;
        sw.switch_recv_ready = '0;
        sw.switch_recv_data  = '0;
        sw.switch_send_ok    = '0;
        sw.switch_pending    = '0;
        for (int d = 0; d < N; d++) begin : g_pop
            logic [AW-1:0] w_src;
            w_src = sw.switch_recv_core_idx[d*AW +: AW];
            if (!reset && sw.switch_recv_request[d] && (32'(w_src) < 32'(N))
                && (r_count[w_src][d] != {CW{1'b0}})) begin
                w_pop[w_src][d]                  = 1'b1;
                sw.switch_recv_ready[d]          = 1'b1;
                sw.switch_recv_data[d*PKT +: PKT] = r_mem[w_src][d][r_rd_ptr[w_src][d]];
            end else begin
                sw.switch_recv_ready[d] = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                sw.switch_pending[d] = sw.switch_pending[d]
                                     | (!reset && (r_count[s][d] != {CW{1'b0}}));
            end
        end
        for (int s = 0; s < N; s++) begin : g_push
            logic [AW-1:0] w_dst;
            w_dst = sw.switch_send_core_idx[s*AW +: AW];
            if (!reset && sw.switch_send_ready[s] && (32'(w_dst) < 32'(N))
                && ((r_count[s][w_dst] < CW'(FIFO_DEPTH)) || w_pop[s][w_dst])) begin
                w_push[s][w_dst]     = 1'b1;
                sw.switch_send_ok[s] = 1'b1;
            end else begin
                sw.switch_send_ok[s] = 1'b0;
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset drops every queued packet.
    always_ff @(posedge clock) begin
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (reset) begin
                    r_rd_ptr[s][d] <= {PW{1'b0}};
                    r_wr_ptr[s][d] <= {PW{1'b0}};
                    r_count[s][d]  <= {CW{1'b0}};
                end else begin
                    if (w_push[s][d]) begin
                        r_wr_ptr[s][d] <= f_next_ptr(r_wr_ptr[s][d]);
                    end
                    if (w_pop[s][d]) begin
                        r_rd_ptr[s][d] <= f_next_ptr(r_rd_ptr[s][d]);
                    end
                    case ({w_push[s][d], w_pop[s][d]})
                        2'b10:   r_count[s][d] <= r_count[s][d] + CW'(1);
                        2'b01:   r_count[s][d] <= r_count[s][d] - CW'(1);
                        default: r_count[s][d] <= r_count[s][d];
                    endcase
                end
            end
        end
    end

    // Packet storage is left uninitialised; occupancy alone decides what is readable.
    always_ff @(posedge clock) begin
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (w_push[s][d]) begin
                    r_mem[s][d][r_wr_ptr[s][d]] <= sw.switch_send_data[s*PKT +: PKT];
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_switch.sv
// Scoreboard bench for vec_switch: a queue-per-pair model predicts every cycle's
// handshakes, pending flags and delivered data; a separate monitor compares.
module tb_vec_switch;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int AW    = 2;
    localparam int PKT   = W * DW;

    typedef struct {
        logic [N-1:0]     ok;
        logic [N-1:0]     rdy;
        logic [N-1:0]     pend;
        logic [N*PKT-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];
    logic [PKT-1:0] mq[N*N][$];

    vec_switch_if #(.SWITCH_CORE_SIZE(N), .SWITCH_WIDTH(W), .DATA_WIDTH(DW),
                    .SWITCH_CORE_ADDR_SIZE(AW)) sw_if();

    vec_switch #(.SWITCH_CORE_SIZE(N), .SWITCH_WIDTH(W), .DATA_WIDTH(DW),
                 .FIFO_DEPTH(DEPTH), .SWITCH_CORE_ADDR_SIZE(AW)) dut (
        .clock (clk),
        .reset (rst),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fbits(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [PKT-1:0] fpkt(input int base);
        logic [PKT-1:0] p;
        for (int i = 0; i < W; i++) p[i*DW +: DW] = fbits(base + i);
        return p;
    endfunction

    function automatic logic [PKT-1:0] rpkt();
        logic [PKT-1:0] p;
        for (int i = 0; i < W; i++) p[i*DW +: DW] = $urandom();
        return p;
    endfunction

    function automatic logic [N*AW-1:0] idx4(input int i0, input int i1, input int i2, input int i3);
        return {2'(i3), 2'(i2), 2'(i1), 2'(i0)};
    endfunction

    task automatic check(input string nm, input logic [PKT-1:0] act, input logic [PKT-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Drive one cycle of inputs and record what the model says the switch must answer.
    task automatic drive(input logic rst_v, input logic [N-1:0] sr, input logic [N*AW-1:0] sidx,
                         input logic [N*PKT-1:0] sdata, input logic [N-1:0] rq,
                         input logic [N*AW-1:0] ridx);
        exp_t e;
        bit popf[N*N];
        bit pushf[N*N];
        logic [PKT-1:0] pdat[N*N];
        @(negedge clk);
        rst = rst_v;
        sw_if.switch_send_ready    = sr;
        sw_if.switch_send_core_idx = sidx;
        sw_if.switch_send_data     = sdata;
        sw_if.switch_recv_request  = rq;
        sw_if.switch_recv_core_idx = ridx;
        e.ok = '0; e.rdy = '0; e.pend = '0; e.data = '0;
        for (int q = 0; q < N*N; q++) begin popf[q] = 0; pushf[q] = 0; pdat[q] = '0; end
        if (rst_v) begin
            for (int q = 0; q < N*N; q++) mq[q].delete();
        end else begin
            for (int d = 0; d < N; d++)
                for (int s = 0; s < N; s++)
                    if (mq[s*N+d].size() > 0) e.pend[d] = 1'b1;
            for (int d = 0; d < N; d++) begin
                int s = int'(ridx[d*AW +: AW]);
                if (rq[d] && mq[s*N+d].size() > 0) begin
                    e.rdy[d] = 1'b1;
                    e.data[d*PKT +: PKT] = mq[s*N+d][0];
                    popf[s*N+d] = 1;
                end
            end
            for (int s = 0; s < N; s++) begin
                int q = s*N + int'(sidx[s*AW +: AW]);
                if (sr[s] && (mq[q].size() < DEPTH || popf[q])) begin
                    e.ok[s] = 1'b1;
                    pushf[q] = 1;
                    pdat[q] = sdata[s*PKT +: PKT];
                end
            end
            for (int q = 0; q < N*N; q++) begin
                if (popf[q]) void'(mq[q].pop_front());
                if (pushf[q]) mq[q].push_back(pdat[q]);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: every cycle the switch presents a full response, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("send_ok", PKT'(sw_if.switch_send_ok), PKT'(e.ok));
                check("recv_ready", PKT'(sw_if.switch_recv_ready), PKT'(e.rdy));
                check("pending", PKT'(sw_if.switch_pending), PKT'(e.pend));
                for (int d = 0; d < N; d++)
                    check($sformatf("recv_data[%0d]", d),
                          sw_if.switch_recv_data[d*PKT +: PKT], e.data[d*PKT +: PKT]);
            end
        end
    end

    initial begin
        logic [N*PKT-1:0] sd;
        logic [PKT-1:0] pa, pb, pc;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        sw_if.switch_send_ready = '0; sw_if.switch_send_core_idx = '0;
        sw_if.switch_send_data = '0;  sw_if.switch_recv_request = '0;
        sw_if.switch_recv_core_idx = '0;

        drive(1'b1, '0, '0, '0, '0, '0);
        drive(1'b1, '0, '0, '0, '0, '0);

        // Basic transfer 0 -> 2 with 1.0 .. 16.0
        sd = '0; sd[0 +: PKT] = fpkt(1);
        drive(1'b0, 4'b0001, idx4(2, 0, 0, 0), sd, 4'b0000, '0);
        drive(1'b0, 4'b0000, '0, '0, 4'b0100, idx4(0, 0, 0, 0));
        idle();

        // Fill 1 -> 3, hold the third packet, then full-plus-pop
        pa = rpkt(); pb = rpkt(); pc = rpkt();
        sd = '0; sd[1*PKT +: PKT] = pa;
        drive(1'b0, 4'b0010, idx4(0, 3, 0, 0), sd, 4'b0000, '0);
        sd[1*PKT +: PKT] = pb;
        drive(1'b0, 4'b0010, idx4(0, 3, 0, 0), sd, 4'b0000, '0);
        sd[1*PKT +: PKT] = pc;
        drive(1'b0, 4'b0010, idx4(0, 3, 0, 0), sd, 4'b0000, '0);
        drive(1'b0, 4'b0010, idx4(0, 3, 0, 0), sd, 4'b1000, idx4(0, 0, 0, 1));
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 4'b1000, idx4(0, 0, 0, 1));

        // Empty request, then two sources into core 0, popped in reverse order
        drive(1'b0, '0, '0, '0, 4'b0001, idx4(3, 0, 0, 0));
        sd = '0; sd[1*PKT +: PKT] = fpkt(100); sd[2*PKT +: PKT] = fpkt(200);
        drive(1'b0, 4'b0110, idx4(0, 0, 0, 0), sd, 4'b0000, '0);
        drive(1'b0, '0, '0, '0, 4'b0001, idx4(2, 0, 0, 0));
        drive(1'b0, '0, '0, '0, 4'b0001, idx4(1, 0, 0, 0));

        // Self-send concurrent with a 0 -> 1 push and a 0 -> 1 pop
        sd = '0; sd[0 +: PKT] = rpkt();
        drive(1'b0, 4'b0001, idx4(1, 0, 0, 0), sd, 4'b0000, '0);
        sd = '0; sd[0 +: PKT] = rpkt(); sd[3*PKT +: PKT] = rpkt();
        drive(1'b0, 4'b1001, idx4(1, 0, 0, 3), sd, 4'b0010, idx4(0, 0, 0, 0));
        for (int i = 0; i < 2; i++) drive(1'b0, '0, '0, '0, 4'b1010, idx4(0, 0, 0, 3));

        // Reset while packets are queued and core 1 is requesting
        sd = '0; sd[0 +: PKT] = rpkt();
        drive(1'b0, 4'b0001, idx4(1, 0, 0, 0), sd, 4'b0000, '0);
        sd[0 +: PKT] = rpkt();
        drive(1'b0, 4'b0001, idx4(1, 0, 0, 0), sd, 4'b0000, '0);
        drive(1'b1, '0, '0, '0, 4'b0010, idx4(0, 0, 0, 0));
        drive(1'b0, '0, '0, '0, 4'b0010, idx4(0, 0, 0, 0));

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            sd = '0;
            for (int s = 0; s < N; s++) sd[s*PKT +: PKT] = rpkt();
            drive(($urandom_range(0, 63) == 0), 4'($urandom()), 8'($urandom()), sd,
                  4'($urandom() & $urandom()), 8'($urandom()));
        end
        idle();

        repeat (2) @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vec_switch.md
Name: vec_switch

Overview:
- Inter-core switch that sits directly behind every vector core's switch port. It carries vector packets of SWITCH_WIDTH single-precision elements from a sending core to a receiving core.
- Each ordered (source, destination) core pair has its own small FIFO. Sends to different destinations never block each other.
- The receiver pulls packets by naming the source core. This matches the core-side send_ready/send_ok and recv_request/recv_ready protocol.

Parameters:
- SWITCH_CORE_SIZE, 4: number of attached vector cores.
- SWITCH_WIDTH, 16: elements per packet.
- DATA_WIDTH, 32: bits per element (IEEE-754 single bit pattern).
- FIFO_DEPTH, 2: packets buffered per (src,dst) pair; must be ≥1.
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE): derived core-index width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- switch_send_ready  in  SWITCH_CORE_SIZE  core c requests to send.
- switch_send_core_idx  in  SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE  destination index, per sending core.
- switch_send_data  in  SWITCH_CORE_SIZE*SWITCH_WIDTH*DATA_WIDTH  packet, per sending core; element 0 in the LSBs.
- switch_send_ok  out  SWITCH_CORE_SIZE  send accepted this cycle.
- switch_recv_request  in  SWITCH_CORE_SIZE  core c requests a packet.
- switch_recv_core_idx  in  SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE  source index, per receiving core.
- switch_recv_ready  out  SWITCH_CORE_SIZE  packet delivered this cycle.
- switch_recv_data  out  SWITCH_CORE_SIZE*SWITCH_WIDTH*DATA_WIDTH  delivered packet, per receiving core.
- switch_pending  out  SWITCH_CORE_SIZE  at least one packet is queued for core c, from any source.

Behaviour:
- State: one FIFO per (s,d) pair.
  - Storage: FIFO_DEPTH × SWITCH_WIDTH × DATA_WIDTH.
  - Pointers: rd_ptr and wr_ptr, wrapping modulo FIFO_DEPTH.
  - Count: 0..FIFO_DEPTH.
- Reset: all counts and pointers go to 0.
  - Reset does not clear storage.
  - Reset mid-operation discards all queued packets; nothing is delivered on the cycle reset is high.
- Outputs are combinational from current state and inputs:
  - switch_send_ok, switch_recv_ready and switch_pending are 0 whenever reset is high or all FIFOs are empty with no requests.
  - switch_recv_data is 0 when switch_recv_ready is low.
- Pop (receiver d, source s = switch_recv_core_idx[d]):
  - Condition: switch_recv_request[d] && s < SWITCH_CORE_SIZE && count[s][d] > 0.
  - When true: switch_recv_ready[d] = 1 and switch_recv_data[d] = head of FIFO[s][d].
  - The FIFO pops at the clock edge.
  - The receiver sees data in the same cycle as its request, with zero-cycle latency.
- Push (sender s, destination d = switch_send_core_idx[s]):
  - Condition: switch_send_ready[s] && d < SWITCH_CORE_SIZE && (count[s][d] < FIFO_DEPTH || pop of FIFO[s][d] this cycle).
  - When true: switch_send_ok[s] = 1 and the packet is written at wr_ptr on the clock edge.
  - The sender holds send_ready and data until it sees send_ok.
  - A packet pushed in cycle N is poppable in cycle N+1 at the earliest. There is no same-cycle bypass, even when the FIFO is empty.
- Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance. This is legal when the FIFO is full, because full-plus-pop accepts the push.
- Self-send (s == d) is legal and uses FIFO[s][s].
- Out-of-range index (possible only when SWITCH_CORE_SIZE is not a power of two): the ok/ready output stays 0 and no state changes.
- Ordering: FIFO order is preserved per (s,d) pair. There is no ordering guarantee across different sources.
- No arbitration is needed: each sender writes only row s and each receiver reads only column d, so every pair has exactly one writer and one reader.
- switch_pending[d] = OR over s of (count[s][d] > 0), computed from the registered counts.

Test Plan:
- Basic transfer: after reset, core 0 sends elements 1.0..16.0 (0x3F800000...) to core 2 in cycle 1.
  - Cycle 1: send_ok[0] = 1.
  - Cycle 2: pending[2] = 1.
  - Cycle 2: recv_request[2] with idx 0 gives recv_ready[2] = 1 with the identical data.
  - Cycle 3: pending[2] = 0.
- Full FIFO, then full-plus-pop:
  - Core 1 sends packets A, B, C to core 3 on consecutive cycles.
  - A and B get send_ok; C is held with send_ok = 0.
  - Core 3 pops in the next cycle and receives A; C is accepted that same cycle.
  - Further pops return B, then C.
- Empty request and ordering: core 0 requests from source 3 when that FIFO is empty.
  - recv_ready[0] = 0 and recv_data[0] = 0.
  - Cores 1 and 2 then both send to core 0 in the same cycle; both get send_ok.
  - Pop from 2 then from 1 returns each source's own packet.
- Self-send and concurrent traffic: in one cycle core 3 sends to itself, core 0 sends to core 1, and core 1 pops from core 0 with one packet already queued.
  - All three handshakes assert in that cycle.
  - Counts afterwards: FIFO[3][3] = 1 and FIFO[0][1] = 1.
- Reset mid-operation: queue 2 packets 0→1, then assert reset for 1 cycle while core 1 requests.
  - During reset: recv_ready[1] = 0.
  - After reset: pending = 0 and a request from idx 0 returns recv_ready = 0.
